mem_dumper: RTL

- Reads a contiguous memory region word by word and streams it out over a UART TX line, 8N1, byte-serial, little-endian.
- It is the reverse of the program loader: a host can capture memory contents (e.g. a result buffer) after a run.
- Sits between the main-memory read port and the board TXD pin.
- Includes its own bit-level UART transmitter.

---
 rtl/mem_dumper.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_dumper.sv
// mem_dumper: reads a contiguous block of words from a memory read port and
// streams the bytes out little-endian over an 8N1 UART transmit line.
module mem_dumper #(
  parameter int          SERIAL_WCNT = 50,
  parameter logic [31:0] DUMP_BASE   = 32'h0,
  parameter int          DUMP_SIZE   = 512 * 1024,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        START,
  output logic [31:0] ADDR,
  output logic        RE,
  input  logic [31:0] RDATA,
  output logic        TXD,
  output logic        BUSY,
  output logic        DONE
);

  localparam int                BAUD_W    = (SERIAL_WCNT > 1) ? $clog2(SERIAL_WCNT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SERIAL_WCNT - 1);
  localparam int                LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [31:0]       NUM_WORDS = 32'(DUMP_SIZE / 4);
  // Bit slots within a frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  localparam logic [3:0]        LAST_DATA = 4'd8;
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [1:0] {IDLE, READ, WAIT, SEND} state_e;

  state_e              state_q, state_d;
  logic [31:0]         waddr_q, waddr_d;   // address of the word being dumped
  logic [31:0]         words_q, words_d;   // words still to send, including current
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [31:0]         shift_q, shift_d;   // captured word, low byte is on the wire
  logic [1:0]          byte_q, byte_d;
  logic [3:0]          bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [31:0]         addr_q, addr_d;
  logic                re_q, re_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  assign ADDR = addr_q;
  assign RE   = re_q;
  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

  // Next-state and next-output logic; registered outputs are computed one
  // cycle ahead so they change together with the state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    waddr_d = waddr_q;
    words_d = words_q;
    lat_d   = lat_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    addr_d  = addr_q;
    re_d    = 1'b0;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (START) begin
          done_d  = 1'b0;
          waddr_d = DUMP_BASE;
          words_d = NUM_WORDS;
          if (NUM_WORDS == 32'd0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            state_d = READ;
            busy_d  = 1'b1;
            re_d    = 1'b1;
            addr_d  = DUMP_BASE;
          end
        end
      end
      READ: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        // The READ cycle counts as the first latency cycle.
        if (lat_q == LAT_LAST) begin
          shift_d = RDATA;
          state_d = SEND;
          byte_d  = 2'd0;
          bit_d   = 4'd0;
          baud_d  = '0;
          txd_d   = 1'b0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SEND: begin
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + 1'b1;
        end else begin
          baud_d = '0;
          if (bit_q != STOP_BIT) begin
            bit_d = bit_q + 4'd1;
            txd_d = (bit_q == LAST_DATA) ? 1'b1 : shift_q[bit_q[2:0]];
          end else if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 4'd0;
            txd_d   = 1'b0;
            shift_d = {8'h00, shift_q[31:8]};
          end else begin
            words_d = words_q - 32'd1;
            waddr_d = waddr_q + 32'd4;
            if (words_q == 32'd1) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = READ;
              re_d    = 1'b1;
              addr_d  = waddr_q + 32'd4;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge.
      state_q <= IDLE;
      waddr_q <= '0;
      words_q <= '0;
      lat_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      words_q <= words_d;
      lat_q   <= lat_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
